// File: rtl/ysyx_23060111_mem_arbiter.sv
// Round-robin arbiter sharing the single data-memory port between IFU (read-only)
// and LSU (read/write), one transaction in flight, with a response watchdog.
module ysyx_23060111_mem_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_ack,
    output logic [31:0] ifu_rdata,
    output logic        ifu_err,
    input  logic        lsu_req,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_ack,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic             OWN_IFU  = 1'b0;
    localparam logic             OWN_LSU  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_owner;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic             r_wen;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wmask;
    logic [31:0]      r_ifu_rdata;
    logic [31:0]      r_lsu_rdata;
    logic             r_ifu_err;
    logic             r_lsu_err;

    logic             w_grant;
    logic             w_grant_lsu;
    logic             w_capture;
    logic             w_timeout;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic [31:0]      w_rsp_data;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_lsu = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ifu_req || lsu_req) begin
                    w_grant     = 1'b1;
                    // On a tie the LSU wins only if the IFU was granted last.
                    w_grant_lsu = lsu_req && (!ifu_req || (r_last_grant == OWN_IFU));
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_ready) begin
                    if (mem_rvalid) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_inc   = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    assign w_rsp_data = w_timeout ? 32'h0 : mem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner      <= OWN_IFU;
            r_last_grant <= OWN_LSU;
            r_cnt        <= '0;
            r_addr       <= 32'h0;
            r_wen        <= 1'b0;
            r_wdata      <= 32'h0;
            r_wmask      <= 4'b0000;
            r_ifu_rdata  <= 32'h0;
            r_lsu_rdata  <= 32'h0;
            r_ifu_err    <= 1'b0;
            r_lsu_err    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_owner      <= w_grant_lsu;
                r_last_grant <= w_grant_lsu;
                r_addr       <= w_grant_lsu ? lsu_addr : ifu_addr;
                r_wen        <= w_grant_lsu & lsu_wen;
                r_wdata      <= w_grant_lsu ? lsu_wdata : 32'h0;
                r_wmask      <= w_grant_lsu ? lsu_wmask : 4'b0000;
            end
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
            if (w_capture || w_timeout) begin
                if (r_owner == OWN_LSU) begin
                    r_lsu_rdata <= w_rsp_data;
                    r_lsu_err   <= w_timeout;
                end else begin
                    r_ifu_rdata <= w_rsp_data;
                    r_ifu_err   <= w_timeout;
                end
            end
        end
    end

    assign mem_valid = (r_state == S_ISSUE);
    assign busy      = (r_state != S_IDLE);
    assign ifu_ack   = (r_state == S_DONE) && (r_owner == OWN_IFU);
    assign lsu_ack   = (r_state == S_DONE) && (r_owner == OWN_LSU);
    assign owner     = r_owner;
    assign mem_addr  = r_addr;
    assign mem_wen   = r_wen;
    assign mem_wdata = r_wdata;
    assign mem_wmask = r_wmask;
    assign ifu_rdata = r_ifu_rdata;
    assign ifu_err   = r_ifu_err;
    assign lsu_rdata = r_lsu_rdata;
    assign lsu_err   = r_lsu_err;

endmodule

// File: tb/tb_ysyx_23060111_mem_arbiter.sv
// Scoreboard bench for the IFU/LSU memory arbiter: directed corner cases followed by
// randomized traffic from both masters against a latency-programmable memory model.
module tb_ysyx_23060111_mem_arbiter;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;

    logic        clk;
    logic        rst;
    logic        ifu_req, ifu_ack, ifu_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req, lsu_wen, lsu_ack, lsu_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        busy, owner;

    ysyx_23060111_mem_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ack(ifu_ack),
        .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_ack(lsu_ack),
        .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        logic        err;
    } txn_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        changed;
    } obs_t;

    txn_t ifu_q[$];
    txn_t lsu_q[$];
    obs_t obs_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Memory latency: fixed by the directed tests, otherwise encoded in address bits.
    bit ovr_en  = 1'b1;
    int ovr_rdy = 0;
    int ovr_rv  = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0093;
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
    endfunction

    // Cycles mem_ready is held low once mem_valid is seen.
    function automatic int rdy_of(input logic [31:0] a);
        return ovr_en ? ovr_rdy : int'(a[3:2]);
    endfunction

    // 0: rvalid together with ready; n>0: rvalid in the n-th cycle after the handshake.
    function automatic int rv_of(input logic [31:0] a);
        if (ovr_en) return ovr_rv;
        return (a[6:4] == 3'd7) ? 0 : int'(a[6:4]) + 1;
    endfunction

    // A response later than TIMEOUT cycles after the handshake is a timeout with zero data.
    function automatic txn_t expect_txn(input logic [31:0] a, input logic w,
                                        input logic [31:0] d, input logic [3:0] m);
        txn_t t;
        t.addr  = a;
        t.wen   = w;
        t.wdata = d;
        t.wmask = m;
        t.err   = (rv_of(a) > TIMEOUT);
        t.rdata = t.err ? 32'h0 : mem_word(a);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ifu_issue(input logic [31:0] a);
        ifu_addr = a;
        ifu_req  = 1'b1;
        ifu_q.push_back(expect_txn(a, 1'b0, 32'h0, 4'b0000));
    endtask

    task automatic lsu_issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input logic [3:0] m);
        lsu_addr  = a;
        lsu_wen   = w;
        lsu_wdata = d;
        lsu_wmask = m;
        lsu_req   = 1'b1;
        lsu_q.push_back(expect_txn(a, w, d, m));
    endtask

    task automatic wait_ack(input bit is_lsu, input int max_cyc, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (is_lsu ? lsu_ack : ifu_ack) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) check(is_lsu ? "lsu_ack_timeout" : "ifu_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Memory responder: records what the arbiter presented, then answers with the
    // latency chosen for that transaction.
    initial begin
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (!mem_valid) continue;
            begin : rsp_txn
                obs_t o;
                int   rdy;
                int   rv;
                bit   aborted;
                o.addr    = mem_addr;
                o.wen     = mem_wen;
                o.wdata   = mem_wdata;
                o.wmask   = mem_wmask;
                o.changed = 1'b0;
                rdy       = rdy_of(mem_addr);
                rv        = rv_of(mem_addr);
                aborted   = 1'b0;
                for (int n = 0; n < rdy; n++) begin
                    mem_ready = 1'b0;
                    @(negedge clk);
                    if (!mem_valid) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (mem_addr !== o.addr || mem_wen !== o.wen ||
                        mem_wdata !== o.wdata || mem_wmask !== o.wmask) o.changed = 1'b1;
                end
                if (!aborted) begin
                    mem_ready = 1'b1;
                    if (rv == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = o.wen ? $urandom() : mem_word(o.addr);
                    end
                    obs_q.push_back(o);
                    @(negedge clk);
                    mem_ready  = 1'b0;
                    mem_rvalid = 1'b0;
                    mem_rdata  = $urandom();
                    if (rv > 0) begin
                        repeat (rv - 1) @(negedge clk);
                        mem_rvalid = 1'b1;
                        mem_rdata  = o.wen ? $urandom() : mem_word(o.addr);
                        @(negedge clk);
                        mem_rvalid = 1'b0;
                        mem_rdata  = $urandom();
                    end
                end
            end
        end
    end

    task automatic score(input bit is_lsu);
        txn_t e;
        obs_t o;
        string p;
        p = is_lsu ? "lsu" : "ifu";
        if ((is_lsu ? lsu_q.size() : ifu_q.size()) == 0 || obs_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_unexpected_ack: got an ack, required none (cycle %0d)", p, cyc);
            return;
        end
        if (is_lsu) e = lsu_q.pop_front();
        else        e = ifu_q.pop_front();
        o = obs_q.pop_front();
        check({p, "_owner"}, owner, is_lsu);
        check({p, "_err"}, is_lsu ? lsu_err : ifu_err, e.err);
        if (!e.wen) check({p, "_rdata"}, is_lsu ? lsu_rdata : ifu_rdata, e.rdata);
        check({p, "_mem_addr"}, o.addr, e.addr);
        check({p, "_mem_wen"}, o.wen, e.wen);
        check({p, "_mem_wmask"}, o.wmask, e.wmask);
        if (e.wen) check({p, "_mem_wdata"}, o.wdata, e.wdata);
        check({p, "_fields_stable"}, o.changed, 1'b0);
    endtask

    // Monitor: every ack cycle pops and compares the oldest expected response.
    initial begin
        forever begin
            @(negedge clk);
            if (ifu_ack || lsu_ack) begin
                check("ack_onehot", ifu_ack & lsu_ack, 1'b0);
                if (ifu_ack) score(1'b0);
                if (lsu_ack) score(1'b1);
            end
        end
    end

    task automatic ifu_driver();
        int t;
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            a      = $urandom();
            a[31]  = 1'b1;
            a[1:0] = 2'b00;
            tick();
            ifu_issue(a);
            wait_ack(1'b0, 100, t);
            if ($urandom_range(0, 2) != 0) begin
                tick();
                ifu_req = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        tick();
        ifu_req = 1'b0;
    endtask

    task automatic lsu_driver();
        int t;
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            logic        w;
            a      = $urandom();
            a[31]  = 1'b1;
            a[1:0] = 2'b00;
            w      = 1'($urandom_range(0, 1));
            tick();
            lsu_issue(a, w, $urandom(), w ? 4'($urandom_range(1, 15)) : 4'b0000);
            wait_ack(1'b1, 100, t);
            if ($urandom_range(0, 2) != 0) begin
                tick();
                lsu_req = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        tick();
        lsu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int t;
        int t_prev;
        int t0;
        rst       = 1'b0;
        ifu_req   = 1'b0;
        ifu_addr  = 32'h0;
        lsu_req   = 1'b0;
        lsu_addr  = 32'h0;
        lsu_wen   = 1'b0;
        lsu_wdata = 32'h0;
        lsu_wmask = 4'b0000;
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        check("rst_busy", busy, 1'b0);
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_acks", {ifu_ack, lsu_ack}, 2'b00);
        check("rst_errs", {ifu_err, lsu_err}, 2'b00);
        check("rst_owner", owner, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wen", mem_wen, 1'b0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wmask", mem_wmask, 4'b0000);
        check("rst_ifu_rdata", ifu_rdata, 32'h0);
        check("rst_lsu_rdata", lsu_rdata, 32'h0);
        rst = 1'b1;

        // Single IFU read, minimum latency: ack in cycle 3
        ovr_rdy = 0;
        ovr_rv  = 1;
        tick();
        ifu_issue(32'h8000_0000);
        @(negedge clk);
        check("rd_c0_busy", busy, 1'b0);
        tick();
        @(negedge clk);
        check("rd_c1_valid", mem_valid, 1'b1);
        check("rd_c1_addr", mem_addr, 32'h8000_0000);
        check("rd_c1_wmask", mem_wmask, 4'b0000);
        check("rd_c1_wen", mem_wen, 1'b0);
        tick();
        @(negedge clk);
        check("rd_c2_valid", mem_valid, 1'b0);
        check("rd_c2_ack", ifu_ack, 1'b0);
        tick();
        @(negedge clk);
        check("rd_c3_ack", ifu_ack, 1'b1);
        check("rd_c3_rdata", ifu_rdata, 32'h0010_0093);
        check("rd_c3_lsu_ack", lsu_ack, 1'b0);
        tick();
        ifu_req = 1'b0;

        // Ties after reset alternate IFU, LSU, IFU with one idle cycle between
        do_reset();
        tick();
        ifu_issue(32'h8000_0010);
        lsu_issue(32'h8000_2000, 1'b0, 32'h0, 4'b0000);
        tick();
        @(negedge clk);
        check("tie1_owner", owner, 1'b0);
        check("tie1_addr", mem_addr, 32'h8000_0010);
        wait_ack(1'b0, 20, t);
        tick();
        ifu_req = 1'b0;
        @(negedge clk);
        check("tie_gap_idle", busy, 1'b0);
        tick();
        @(negedge clk);
        check("tie2_owner", owner, 1'b1);
        check("tie2_addr", mem_addr, 32'h8000_2000);
        wait_ack(1'b1, 20, t);
        tick();
        ifu_issue(32'h8000_0020);
        lsu_issue(32'h8000_2040, 1'b0, 32'h0, 4'b0000);
        tick();
        @(negedge clk);
        check("tie3_owner", owner, 1'b0);
        wait_ack(1'b0, 20, t);
        tick();
        ifu_req = 1'b0;
        wait_ack(1'b1, 20, t);
        tick();
        lsu_req = 1'b0;

        // LSU store with mem_ready low for three cycles
        ovr_rdy = 3;
        ovr_rv  = 1;
        tick();
        lsu_issue(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            check("st_valid", mem_valid, 1'b1);
            check("st_wen", mem_wen, 1'b1);
            check("st_addr", mem_addr, 32'h8000_1000);
            check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("st_wmask", mem_wmask, 4'b0011);
        end
        wait_ack(1'b1, 20, t);
        tick();
        lsu_req = 1'b0;

        // Watchdog: no response -> error ack four cycles after entering WAIT
        ovr_rdy = 0;
        ovr_rv  = 7;
        tick();
        lsu_issue(32'h8000_3000, 1'b0, 32'h0, 4'b0000);
        tick();
        @(negedge clk);
        check("to_issue", mem_valid, 1'b1);
        for (int c = 2; c <= 5; c++) begin
            tick();
            @(negedge clk);
            check("to_early_ack", lsu_ack, 1'b0);
        end
        tick();
        @(negedge clk);
        check("to_ack", lsu_ack, 1'b1);
        check("to_err", lsu_err, 1'b1);
        check("to_rdata", lsu_rdata, 32'h0);
        tick();
        lsu_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("to_stray_ack", {ifu_ack, lsu_ack}, 2'b00);
            tick();
        end

        // Back-to-back IFU, ready and rvalid together: ack 2 after grant, then every 3
        ovr_rdy = 0;
        ovr_rv  = 0;
        tick();
        t0 = cyc;
        ifu_issue(32'h8000_0100);
        wait_ack(1'b0, 20, t);
        check("b2b_first_lat", t - t0, 32'd2);
        for (int k = 1; k < 4; k++) begin
            t_prev = t;
            tick();
            ifu_issue(32'h8000_0100 + 32'(k * 4));
            wait_ack(1'b0, 20, t);
            check("b2b_period", t - t_prev, 32'd3);
        end
        tick();
        ifu_req = 1'b0;

        // Reset mid-WAIT abandons the fetch; afterwards IFU again wins a tie
        ovr_rdy = 0;
        ovr_rv  = 6;
        tick();
        ifu_issue(32'h8000_4000);
        tick();
        tick();
        @(negedge clk);
        check("mr_busy_wait", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("mr_busy_async", busy, 1'b0);
        check("mr_valid_async", mem_valid, 1'b0);
        ifu_q.delete();
        lsu_q.delete();
        obs_q.delete();
        ifu_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            @(negedge clk);
            check("mr_no_ack", {ifu_ack, lsu_ack}, 2'b00);
        end
        ovr_rv = 1;
        tick();
        ifu_issue(32'h8000_0200);
        lsu_issue(32'h8000_2200, 1'b0, 32'h0, 4'b0000);
        tick();
        @(negedge clk);
        check("mr_tie_owner", owner, 1'b0);
        wait_ack(1'b0, 20, t);
        tick();
        ifu_req = 1'b0;
        wait_ack(1'b1, 20, t);
        tick();
        lsu_req = 1'b0;

        // Randomized traffic from both masters with address-encoded memory latency
        ovr_en = 1'b0;
        repeat (4) tick();
        fork
            ifu_driver();
            lsu_driver();
        join
        repeat (12) tick();
        check("end_ifu_q_empty", ifu_q.size(), 32'd0);
        check("end_lsu_q_empty", lsu_q.size(), 32'd0);
        check("end_obs_q_empty", obs_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060111_mem_arbiter.md
Name: ysyx_23060111_mem_arbiter

Overview:
Two-master, one-slave arbiter that shares the single data memory port between the instruction-fetch unit (read-only) and the load/store path of the execute unit (read/write). Only one transaction is outstanding at a time. Arbitration is round-robin. A response watchdog returns an error if memory stalls. It sits between IFU/EXU and ysyx_23060111_mem and replaces their direct connection.

Parameters:
TIMEOUT, 64, max cycles in WAIT before a forced error response (must be >=2)
CNT_W, 7, width of watchdog counter (must hold TIMEOUT)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ifu_req  in  1  IFU fetch request, held until ifu_ack
ifu_addr  in  32  fetch address
ifu_ack  out  1  one-cycle completion pulse to IFU
ifu_rdata  out  32  fetched word, valid when ifu_ack=1
ifu_err  out  1  timeout flag, valid when ifu_ack=1
lsu_req  in  1  load/store request, held until lsu_ack
lsu_addr  in  32  access address
lsu_wen  in  1  1=store, 0=load
lsu_wdata  in  32  store data
lsu_wmask  in  4  byte enables for store
lsu_ack  out  1  one-cycle completion pulse to LSU
lsu_rdata  out  32  load data, valid when lsu_ack=1
lsu_err  out  1  timeout flag, valid when lsu_ack=1
mem_valid  out  1  request valid to memory
mem_ready  in  1  memory accepts request
mem_addr  out  32  registered address
mem_wen  out  1  registered write enable
mem_wdata  out  32  registered write data
mem_wmask  out  4  registered byte mask (4'b0000 for IFU)
mem_rvalid  in  1  memory response valid (reads and writes)
mem_rdata  in  32  memory read data
busy  out  1  1 whenever state != IDLE
owner  out  1  0=IFU, 1=LSU; current/last granted master

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Registered state, address/data/mask, owner, last_grant, watchdog counter, rdata, err.
- Reset (rst=0, async): state=IDLE; mem_valid, mem_wen, ifu_ack, lsu_ack, ifu_err, lsu_err, busy=0; mem_addr, mem_wdata, ifu_rdata, lsu_rdata=0; mem_wmask=0; owner=0; last_grant=LSU, so IFU wins the first tie. Reset mid-transaction abandons it with no ack. mem_valid drops asynchronously.
- IDLE: sample the reqs. Only one req -> grant it. Both -> grant the master not equal to last_grant. On grant: latch fields, set owner and last_grant, go to ISSUE. If neither req is high, stay in IDLE.
- ISSUE: mem_valid=1, fields stable. mem_ready=1 -> WAIT, counter=0. If mem_rvalid=1 in the same cycle -> DONE directly with rdata captured.
- WAIT: mem_valid=0. mem_rvalid=1 -> capture mem_rdata, err=0, go to DONE. Otherwise counter+1. If counter==TIMEOUT-1 with no rvalid -> rdata=0, err=1, go to DONE.
- DONE: owner's ack=1 for exactly one cycle; the matching rdata and err are valid. The other master's ack=0. Next state is IDLE.
- mem_rvalid in IDLE/DONE and after a timeout is ignored (stray response is dropped).
- Minimum latency: req in cycle 0, ISSUE in cycle 1 (ready), WAIT in cycle 2 (rvalid), ack in cycle 3.
- Masters keep req and fields stable until ack. req still high in the cycle after ack = new request, arbitrated normally in IDLE.
- ifu_rdata/lsu_rdata hold their last value outside ack.
- Store response data is don't-care. The ack is required.

Test Plan:
- Single IFU read: ifu_req, addr 0x80000000, mem_ready=1 immediately, rvalid next cycle with 0x00100093 -> ifu_ack in cycle 3, ifu_rdata=0x00100093, err=0, mem_wmask=0.
- Tie after reset: both reqs high -> IFU served first (owner=0). LSU is served next, with one IDLE cycle between transactions. Third tie -> IFU again.
- LSU store: addr 0x80001000, wdata 0xDEADBEEF, wmask 4'b0011 -> mem_wen=1 and fields exactly as given while mem_valid=1. mem_ready held 0 for 3 cycles: mem_valid stays 1 and fields stay stable. lsu_ack arrives after rvalid.
- Timeout with TIMEOUT=4: mem_ready=1, no rvalid -> lsu_ack exactly 4 cycles after entering WAIT, lsu_err=1, lsu_rdata=0. A later rvalid in IDLE causes no ack.
- Reset mid-WAIT: rst=0 -> mem_valid, busy=0 immediately, no ack ever. After release, IFU wins the first tie.
- Back-to-back IFU with ready and rvalid in the same ISSUE cycle -> ack 2 cycles after grant. Continuous ifu_req yields one ack every 3 cycles.
